// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences core reset, counts RUN cycles,
// and ends a run on PC self-loop, halt-address fetch or cycle budget exhaustion.
module mips_run_ctrl #(
   parameter int              PC_W         = 32,
   parameter int              CNT_W        = 32,
   parameter int              RESET_CYCLES = 4,
   parameter int              MAX_CYCLES   = 100000,
   parameter int              HALT_REPEAT  = 3,
   parameter int              HALT_MODE    = 0,
   parameter logic [PC_W-1:0] HALT_PC      = PC_W'(32'h0000_3FFC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             pc_valid,
   output logic             core_reset,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int   REP_W    = $clog2(HALT_REPEAT + 1);
   localparam int   RST_W    = $clog2(RESET_CYCLES + 1);
   localparam logic LOOP_EN  = (HALT_MODE != 1);
   localparam logic MATCH_EN = (HALT_MODE != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST    = 3'd1,
      S_RUN    = 3'd2,
      S_HALTED = 3'd3,
      S_TMO    = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [RST_W-1:0]  rst_cnt_r;
   logic [REP_W-1:0]  rep_cnt_r;
   logic [REP_W-1:0]  rep_upd_s;
   logic [PC_W-1:0]   last_pc_r;
   logic              loop_hit_s;
   logic              pc_hit_s;
   logic              halt_s;
   logic              budget_s;
   logic              launch_s;
   logic              core_reset_s;
   logic              running_s;

   // Termination detection for the current RUN cycle
   always_comb begin
      rep_upd_s = {{(REP_W-1){1'b0}}, 1'b1};
      if (rep_cnt_r == {REP_W{1'b0}} || pc_in != last_pc_r) begin
         rep_upd_s = {{(REP_W-1){1'b0}}, 1'b1};
      end else begin
         rep_upd_s = rep_cnt_r + {{(REP_W-1){1'b0}}, 1'b1};
      end
      loop_hit_s = LOOP_EN && pc_valid && (rep_upd_s == REP_W'(HALT_REPEAT));
      pc_hit_s   = MATCH_EN && pc_valid && (pc_in == HALT_PC);
      halt_s     = loop_hit_s || pc_hit_s;
      budget_s   = ((cycle_count + {{(CNT_W-1){1'b0}}, 1'b1}) == CNT_W'(MAX_CYCLES));
      launch_s   = start && (state_r == S_IDLE || state_r == S_HALTED || state_r == S_TMO);
   end

   // Next-state logic; halt takes priority over budget exhaustion
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_HALTED, S_TMO: begin
            if (start) state_nxt_s = S_RST;
            else       state_nxt_s = state_r;
         end
         S_RST: begin
            if (rst_cnt_r == RST_W'(RESET_CYCLES - 1)) state_nxt_s = S_RUN;
            else                                       state_nxt_s = S_RST;
         end
         S_RUN: begin
            if (halt_s)        state_nxt_s = S_HALTED;
            else if (budget_s) state_nxt_s = S_TMO;
            else               state_nxt_s = S_RUN;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs move with the state
   always_comb begin
      core_reset_s = (state_nxt_s != S_RUN);
      running_s    = (state_nxt_s == S_RUN);
   end

   // State and control-output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_IDLE;
         core_reset <= 1'b1;
         running    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         core_reset <= core_reset_s;
         running    <= running_s;
      end
   end

   // Counters, loop tracker and sticky status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt_r   <= {RST_W{1'b0}};
         rep_cnt_r   <= {REP_W{1'b0}};
         last_pc_r   <= {PC_W{1'b0}};
         cycle_count <= {CNT_W{1'b0}};
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else if (launch_s) begin
         rst_cnt_r   <= {RST_W{1'b0}};
         rep_cnt_r   <= {REP_W{1'b0}};
         last_pc_r   <= {PC_W{1'b0}};
         cycle_count <= {CNT_W{1'b0}};
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else if (state_r == S_RST) begin
         rst_cnt_r <= rst_cnt_r + {{(RST_W-1){1'b0}}, 1'b1};
      end else if (state_r == S_RUN) begin
         cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
         // Stalled cycles leave the loop tracker untouched
         if (LOOP_EN && pc_valid) begin
            last_pc_r <= pc_in;
            rep_cnt_r <= rep_upd_s;
         end
         if (halt_s) begin
            done <= 1'b1;
         end else if (budget_s) begin
            done    <= 1'b1;
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: three instances (self-loop, PC-match, both with a short budget)
// share stimulus and are compared every cycle against a history-based reference model.
module tb_mips_run_ctrl;

   localparam int          RC  = 4;
   localparam int          HR  = 3;
   localparam logic [31:0] HPC = 32'h0000_3FFC;
   localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_HALT = 3, P_TMO = 4;

   logic        clk = 1'b0;
   logic        reset, start, pc_valid;
   logic [31:0] pc_in;
   logic        cr [3];
   logic        rn [3];
   logic        dn [3];
   logic        to [3];
   logic [31:0] cc [3];

   int errors = 0;
   int checks = 0;

   // reference model state per instance
   int          m_ph   [3];
   int          m_rst  [3];
   int unsigned m_cyc  [3];
   bit          m_done [3];
   bit          m_tmo  [3];
   int          m_nv   [3];
   logic [31:0] m_hist [3][HR];

   always #5 clk = ~clk;

   mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(100000),
                   .HALT_REPEAT(HR), .HALT_MODE(0), .HALT_PC(HPC)) u_m0 (
      .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
      .core_reset(cr[0]), .running(rn[0]), .done(dn[0]), .timeout(to[0]), .cycle_count(cc[0]));

   mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(100000),
                   .HALT_REPEAT(HR), .HALT_MODE(1), .HALT_PC(HPC)) u_m1 (
      .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
      .core_reset(cr[1]), .running(rn[1]), .done(dn[1]), .timeout(to[1]), .cycle_count(cc[1]));

   mips_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(RC), .MAX_CYCLES(20),
                   .HALT_REPEAT(HR), .HALT_MODE(2), .HALT_PC(HPC)) u_m2 (
      .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
      .core_reset(cr[2]), .running(rn[2]), .done(dn[2]), .timeout(to[2]), .cycle_count(cc[2]));

   function automatic int max_of(int i);
      return (i == 2) ? 20 : 100000;
   endfunction

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance every model by one clock edge using the inputs sampled on that edge
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         bit loop_hit;
         bit pc_hit;
         if (reset) begin
            m_ph[i] = P_IDLE; m_cyc[i] = 0; m_done[i] = 1'b0; m_tmo[i] = 1'b0; m_nv[i] = 0;
         end else begin
            case (m_ph[i])
               P_RST: begin
                  m_rst[i]++;
                  if (m_rst[i] == RC) m_ph[i] = P_RUN;
               end
               P_RUN: begin
                  m_cyc[i]++;
                  if (pc_valid) begin
                     for (int k = HR - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                     m_hist[i][0] = pc_in;
                     m_nv[i]++;
                  end
                  loop_hit = 1'b0;
                  if (i != 1 && pc_valid && m_nv[i] >= HR) begin
                     loop_hit = 1'b1;
                     for (int k = 1; k < HR; k++)
                        if (m_hist[i][k] != m_hist[i][0]) loop_hit = 1'b0;
                  end
                  pc_hit = (i != 0) && pc_valid && (pc_in == HPC);
                  if (loop_hit || pc_hit) begin
                     m_ph[i] = P_HALT; m_done[i] = 1'b1;
                  end else if (m_cyc[i] == max_of(i)) begin
                     m_ph[i] = P_TMO; m_done[i] = 1'b1; m_tmo[i] = 1'b1;
                  end
               end
               default: begin
                  if (start) begin
                     m_ph[i] = P_RST; m_rst[i] = 0; m_cyc[i] = 0;
                     m_done[i] = 1'b0; m_tmo[i] = 1'b0; m_nv[i] = 0;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("core_reset%0d", i),  64'(cr[i]), 64'(m_ph[i] != P_RUN));
         chk_eq($sformatf("running%0d", i),     64'(rn[i]), 64'(m_ph[i] == P_RUN));
         chk_eq($sformatf("done%0d", i),        64'(dn[i]), 64'(m_done[i]));
         chk_eq($sformatf("timeout%0d", i),     64'(to[i]), 64'(m_tmo[i]));
         chk_eq($sformatf("cycle_count%0d", i), 64'(cc[i]), 64'(m_cyc[i]));
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] p);
      reset = r; start = s; pc_valid = v; pc_in = p;
      tick();
   endtask

   // Reset, start, and step through the reset phase so the next tick is RUN cycle 1
   task automatic begin_run();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (RC) drive(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_ph[i] = P_IDLE; m_rst[i] = 0; m_cyc[i] = 0;
         m_done[i] = 1'b0; m_tmo[i] = 1'b0; m_nv[i] = 0;
      end

      // reset held for edges 1..3, start sampled at edge 10
      repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk_eq("reset_core_reset", 64'(cr[0]), 64'd1);
      chk_eq("reset_cycle_count", 64'(cc[0]), 64'd0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk_eq("edge13_core_reset", 64'(cr[0]), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk_eq("edge14_core_reset", 64'(cr[0]), 64'd0);
      chk_eq("edge14_running", 64'(rn[0]), 64'd1);
      chk_eq("edge14_cycle_count", 64'(cc[0]), 64'd0);

      // self-loop after three identical fetches
      drive(1'b0, 1'b0, 1'b1, 32'h3000);
      drive(1'b0, 1'b0, 1'b1, 32'h3004);
      repeat (3) drive(1'b0, 1'b0, 1'b1, 32'h3008);
      chk_eq("loop_done", 64'(dn[0]), 64'd1);
      chk_eq("loop_timeout", 64'(to[0]), 64'd0);
      chk_eq("loop_count", 64'(cc[0]), 64'd5);

      // restart from HALTED clears done on the start edge
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk_eq("restart_done", 64'(dn[0]), 64'd0);

      // stalls neither break nor advance a loop
      begin_run();
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      drive(1'b0, 1'b0, 1'b0, 32'h1234);
      drive(1'b0, 1'b0, 1'b0, 32'h3008);
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      chk_eq("stall_done", 64'(dn[0]), 64'd1);
      chk_eq("stall_count", 64'(cc[0]), 64'd5);

      begin_run();
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      drive(1'b0, 1'b0, 1'b0, 32'h3008);
      drive(1'b0, 1'b0, 1'b1, 32'h300C);
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      drive(1'b0, 1'b0, 1'b1, 32'h3008);
      chk_eq("broken_loop_done", 64'(dn[0]), 64'd0);

      // halt-address fetch after 1024 sequential fetches
      begin_run();
      for (int i = 0; i < 1024; i++) drive(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(i) * 32'd4);
      chk_eq("pcmatch_done", 64'(dn[1]), 64'd1);
      chk_eq("pcmatch_timeout", 64'(to[1]), 64'd0);
      chk_eq("pcmatch_count", 64'(cc[1]), 64'd1024);

      // budget of 20 with an ever-changing PC
      begin_run();
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 32'h5000 + 32'(i) * 32'd4);
      chk_eq("tmo_done", 64'(dn[2]), 64'd1);
      chk_eq("tmo_timeout", 64'(to[2]), 64'd1);
      chk_eq("tmo_count", 64'(cc[2]), 64'd20);

      // loop completes exactly on the last budgeted cycle: halt wins
      begin_run();
      for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 1'b1, 32'h5000 + 32'(i) * 32'd4);
      repeat (3) drive(1'b0, 1'b0, 1'b1, 32'h6000);
      chk_eq("tie_done", 64'(dn[2]), 64'd1);
      chk_eq("tie_timeout", 64'(to[2]), 64'd0);
      chk_eq("tie_count", 64'(cc[2]), 64'd20);

      // reset during RUN cycle 7 aborts the run
      begin_run();
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 32'h7000 + 32'(i) * 32'd4);
      drive(1'b1, 1'b0, 1'b1, 32'h7100);
      chk_eq("abort_core_reset", 64'(cr[0]), 64'd1);
      chk_eq("abort_running", 64'(rn[0]), 64'd0);
      chk_eq("abort_count", 64'(cc[0]), 64'd0);

      // random traffic over a small PC set so loops and halt fetches occur
      for (int n = 0; n < 3000; n++) begin
         logic        r, s, v;
         int unsigned sel;
         logic [31:0] p;
         r   = ($urandom_range(0, 63) == 0);
         s   = ($urandom_range(0, 15) == 0);
         v   = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 3);
         p   = (sel == 3) ? HPC : (32'h3000 + 32'(sel) * 32'd4);
         drive(r, s, v, p);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
